// File: rtl/mem_responder.sv
// Single-outstanding memory responder with a word-addressed backing store and fixed response latency.
// Optional macro MEM_MISALIGN_CHECK_EN faults misaligned half/word accesses instead of truncating strobes.
module mem_responder #(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_req_valid,
  output logic        mem_req_ready,
  input  logic [31:0] mem_req_addr,
  input  logic        mem_req_we,
  input  logic [1:0]  mem_req_size,
  input  logic [31:0] mem_req_wdata,
  output logic        mem_resp_valid,
  input  logic        mem_resp_ready,
  output logic [31:0] mem_resp_rdata,
  output logic        mem_resp_err
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [31:0] mem [DEPTH];

  logic          accept;
  logic          in_range;
  logic          misalign;
  logic          fault;
  logic          wr_en;
  logic [AW-1:0] idx;
  logic [1:0]    off;
  logic [3:0]    strb;
  logic [31:0]   wdata_sh;

  assign off      = mem_req_addr[1:0];
  assign idx      = mem_req_addr[AW+1:2];
  assign in_range = (mem_req_addr[31:AW+2] == '0);

`ifdef MEM_MISALIGN_CHECK_EN
  // Size 11 behaves as a word, so size[1] covers both word encodings.
  assign misalign = ((mem_req_size == 2'b01) && off[0]) ||
                    (mem_req_size[1] && (off != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  assign fault = !in_range || misalign;

  // Ready is gated by reset so nothing is accepted while rst is low.
  assign mem_req_ready = rst && (state_q == IDLE);
  assign accept        = mem_req_valid && mem_req_ready;
  assign wr_en         = accept && mem_req_we && !fault;

  // Lanes shifted past byte 3 fall off the 4-bit strobe, truncating at the word boundary.
  always_comb begin
    case (mem_req_size)
      2'b00:   strb = 4'b0001 << off;
      2'b01:   strb = 4'b0011 << off;
      default: strb = 4'b1111 << off;
    endcase
  end

  assign wdata_sh = mem_req_wdata << {off, 3'b000};

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (strb[i]) mem[idx][8*i +: 8] <= wdata_sh[8*i +: 8];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          cnt_d   = 4'(LATENCY);
          state_d = (LATENCY == 0) ? RESP : WAIT;
          err_d   = fault;
          rdata_d = (mem_req_we || fault) ? 32'h0 : mem[idx];
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = RESP;
      end
      RESP: begin
        if (mem_resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign mem_resp_valid = (state_q == RESP);
  assign mem_resp_rdata = rdata_q;
  assign mem_resp_err   = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Randomized bench for mem_responder against a byte-level memory model; covers a LATENCY=2 and a LATENCY=0 instance.
module tb_mem_responder;

  logic        clk;
  logic        rst;
  logic        sel;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        req_we;
  logic [1:0]  req_size;
  logic [31:0] req_wdata;
  logic        resp_ready;

  logic        a_req_ready, a_resp_valid, a_resp_err;
  logic [31:0] a_resp_rdata;
  logic        b_req_ready, b_resp_valid, b_resp_err;
  logic [31:0] b_resp_rdata;

  logic        req_ready, resp_valid, resp_err;
  logic [31:0] resp_rdata;

  int total = 0;
  int bad   = 0;

  logic [7:0] mb [2][4096];

  mem_responder #(.DEPTH(1024), .LATENCY(2)) u_dut (
    .clk            (clk),
    .rst            (rst),
    .mem_req_valid  (req_valid && !sel),
    .mem_req_ready  (a_req_ready),
    .mem_req_addr   (req_addr),
    .mem_req_we     (req_we),
    .mem_req_size   (req_size),
    .mem_req_wdata  (req_wdata),
    .mem_resp_valid (a_resp_valid),
    .mem_resp_ready (resp_ready && !sel),
    .mem_resp_rdata (a_resp_rdata),
    .mem_resp_err   (a_resp_err)
  );

  mem_responder #(.DEPTH(16), .LATENCY(0)) u_dut0 (
    .clk            (clk),
    .rst            (rst),
    .mem_req_valid  (req_valid && sel),
    .mem_req_ready  (b_req_ready),
    .mem_req_addr   (req_addr),
    .mem_req_we     (req_we),
    .mem_req_size   (req_size),
    .mem_req_wdata  (req_wdata),
    .mem_resp_valid (b_resp_valid),
    .mem_resp_ready (resp_ready && sel),
    .mem_resp_rdata (b_resp_rdata),
    .mem_resp_err   (b_resp_err)
  );

  assign req_ready  = sel ? b_req_ready  : a_req_ready;
  assign resp_valid = sel ? b_resp_valid : a_resp_valid;
  assign resp_rdata = sel ? b_resp_rdata : a_resp_rdata;
  assign resp_err   = sel ? b_resp_err   : a_resp_err;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Byte-addressed reference: stores write bytes a..a+n-1 that stay inside the word.
  task automatic model(input bit s, input logic we, input logic [1:0] sz,
                       input logic [31:0] a, input logic [31:0] wd,
                       output logic [31:0] rd, output logic er);
    int n;
    int dep;
    dep = s ? 16 : 1024;
    n   = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    er  = (a >= 32'(4 * dep));
`ifdef MEM_MISALIGN_CHECK_EN
    if ((a % n) != 0) er = 1'b1;
`endif
    rd = 32'h0;
    if (!er) begin
      if (we) begin
        for (int k = 0; k < n; k++) begin
          if ((a % 4) + k < 4) mb[s][a + k] = wd[8*k +: 8];
        end
      end else begin
        for (int k = 0; k < 4; k++) rd[8*k +: 8] = mb[s][(a & ~32'h3) + k];
      end
    end
  endtask

  // Runs one request on the selected instance; called with the clock at a negedge, returns at a negedge.
  task automatic txn(input bit s, input logic we, input logic [1:0] sz,
                     input logic [31:0] a, input logic [31:0] wd, input int hold);
    logic [31:0] exp_rd;
    logic        exp_er;
    int          n;
    int          lat;
    int          exp_lat;
    model(s, we, sz, a, wd, exp_rd, exp_er);
    exp_lat   = s ? 1 : 3;
    sel       = s;
    req_we    = we;
    req_size  = sz;
    req_addr  = a;
    req_wdata = wd;
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) chk("req_ready_timeout", 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", 32'(lat), 32'(exp_lat));
    chk("rdata", resp_rdata, exp_rd);
    chk("err", 32'(resp_err), 32'(exp_er));
    chk("busy_ready", 32'(req_ready), 32'd0);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_valid", 32'(resp_valid), 32'd1);
      chk("hold_rdata", resp_rdata, exp_rd);
      chk("hold_ready", 32'(req_ready), 32'd0);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    chk("idle_ready", 32'(req_ready), 32'd1);
    chk("idle_valid", 32'(resp_valid), 32'd0);
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] wd;
    logic [1:0]  sz;
    logic        we;
    rst        = 1'b0;
    sel        = 1'b0;
    req_valid  = 1'b0;
    req_addr   = 32'h0;
    req_we     = 1'b0;
    req_size   = 2'b00;
    req_wdata  = 32'h0;
    resp_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", 32'(a_req_ready), 32'd0);
    chk("rst_resp_valid", 32'(a_resp_valid), 32'd0);
    chk("rst_rdata", a_resp_rdata, 32'h0);
    chk("rst_err", 32'(a_resp_err), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", 32'(a_req_ready), 32'd1);

    // Fill the first 16 words so every later load reads defined data.
    for (int w = 0; w < 16; w++) txn(1'b0, 1'b1, 2'b10, 32'(4 * w), $urandom, 0);

    txn(1'b0, 1'b1, 2'b10, 32'h10, 32'hDEADBEEF, 0);
    txn(1'b0, 1'b0, 2'b10, 32'h10, 32'h0, 0);
    txn(1'b0, 1'b1, 2'b10, 32'h10, 32'h11223344, 0);
    txn(1'b0, 1'b1, 2'b00, 32'h13, 32'h000000AA, 0);
    txn(1'b0, 1'b0, 2'b10, 32'h10, 32'h0, 0);
    chk("byte_merge_const", {mb[0][32'h13], mb[0][32'h12], mb[0][32'h11], mb[0][32'h10]}, 32'hAA223344);
    txn(1'b0, 1'b0, 2'b10, 32'h10, 32'h0, 5);

    txn(1'b0, 1'b0, 2'b10, 32'h1000, 32'h0, 0);
    txn(1'b0, 1'b1, 2'b10, 32'h1000, 32'hCAFEF00D, 0);
    txn(1'b0, 1'b0, 2'b10, 32'h0, 32'h0, 0);
    txn(1'b0, 1'b0, 2'b10, 32'h10, 32'h0, 0);

    txn(1'b0, 1'b1, 2'b10, 32'h21, 32'h55667788, 0);
    txn(1'b0, 1'b0, 2'b10, 32'h20, 32'h0, 0);

    for (int i = 0; i < 200; i++) begin
      we = 1'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 3));
      wd = $urandom;
      if ($urandom_range(0, 9) == 0) a = $urandom | 32'h0000_1000;
      else a = 32'($urandom_range(0, 63));
      txn(1'b0, we, sz, a, wd, $urandom_range(0, 2));
    end

    // Reset while a load sits in WAIT: the load must vanish, memory must survive.
    sel       = 1'b0;
    req_we    = 1'b0;
    req_size  = 2'b10;
    req_addr  = 32'h10;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    chk("wait_valid", 32'(a_resp_valid), 32'd0);
    rst = 1'b0;
    #1;
    chk("midrst_ready", 32'(a_req_ready), 32'd0);
    chk("midrst_valid", 32'(a_resp_valid), 32'd0);
    chk("midrst_rdata", a_resp_rdata, 32'h0);
    chk("midrst_err", 32'(a_resp_err), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("no_resp_after_rst", 32'(a_resp_valid), 32'd0);
    end
    chk("ready_after_rst", 32'(a_req_ready), 32'd1);
    txn(1'b0, 1'b0, 2'b10, 32'h10, 32'h0, 0);
    txn(1'b0, 1'b0, 2'b10, 32'h3C, 32'h0, 1);

    txn(1'b1, 1'b1, 2'b10, 32'h4, 32'h0BADCAFE, 0);
    txn(1'b1, 1'b0, 2'b10, 32'h4, 32'h0, 0);
    txn(1'b1, 1'b1, 2'b01, 32'h6, 32'h00001234, 2);
    txn(1'b1, 1'b0, 2'b10, 32'h4, 32'h0, 0);
    txn(1'b1, 1'b0, 2'b10, 32'h40, 32'h0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
